// File: rtl/apb_timer_slave.sv
// APB timer slave: 32-bit down-counter with prescaler, auto-reload and level IRQ.
// Zero-wait-state register file behind the bridge's fixed two-cycle transfer.
module apb_timer_slave #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                  H_CLK,
    input  logic                  H_RESET,
    input  logic                  P_SELx,
    input  logic                  P_ENABLE,
    input  logic                  P_WRITE,
    input  logic [ADDR_WIDTH-1:0] P_ADDR,
    input  logic [DATA_WIDTH-1:0] P_WDATA,
    output logic [DATA_WIDTH-1:0] P_RDATA,
    output logic                  TIMER_IRQ
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_VALUE  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam logic [DATA_WIDTH-1:0]     VAL_ONE = DATA_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = PRESCALE_WIDTH'(1);

    apb_state_t state;
    apb_state_t state_nxt;

    logic                      en;
    logic                      auto_reload;
    logic                      irq_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] psc_cnt;
    logic [DATA_WIDTH-1:0]     load;
    logic [DATA_WIDTH-1:0]     value;
    logic                      expired;

    logic [1:0] reg_sel;
    logic       commit;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_status;
    logic       en_rise;
    logic       tick;
    logic       expire;
    logic       unused_addr;

    assign reg_sel     = P_ADDR[3:2];
    assign unused_addr = ^{P_ADDR[ADDR_WIDTH-1:4], P_ADDR[1:0]};

    // APB transfer tracking
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (P_SELx && !P_ENABLE) state_nxt = SETUP;
            SETUP:   if (P_SELx && P_ENABLE)  state_nxt = ACCESS;
            ACCESS:  if (P_SELx && !P_ENABLE) state_nxt = SETUP;
            default: state_nxt = IDLE;
        endcase
        if (!P_SELx) state_nxt = IDLE;
    end

    always_ff @(posedge H_CLK) begin
        if (H_RESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Only the SETUP->ACCESS edge commits; a held ACCESS never re-writes.
    assign commit    = (state == SETUP) && P_SELx && P_ENABLE && P_WRITE;
    assign wr_ctrl   = commit && (reg_sel == OFF_CTRL);
    assign wr_load   = commit && (reg_sel == OFF_LOAD);
    assign wr_status = commit && (reg_sel == OFF_STATUS);
    assign en_rise   = wr_ctrl && P_WDATA[0] && !en;

    assign tick   = en && (psc_cnt == prescale);
    assign expire = tick && (value == '0);

    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
        end else if (wr_ctrl) begin
            en          <= P_WDATA[0];
            auto_reload <= P_WDATA[1];
            irq_en      <= P_WDATA[2];
            prescale    <= P_WDATA[8 +: PRESCALE_WIDTH];
        end else if (expire && !auto_reload) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge H_CLK) begin
        if (H_RESET)      load <= '0;
        else if (wr_load) load <= P_WDATA;
    end

    // A LOAD write overrides whatever the tick would have done.
    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            value <= '0;
        end else if (wr_load) begin
            value <= P_WDATA;
        end else if (tick) begin
            if (value != '0)      value <= value - VAL_ONE;
            else if (auto_reload) value <= load;
        end
    end

    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            psc_cnt <= '0;
        end else if (wr_load || en_rise) begin
            psc_cnt <= '0;
        end else if (en) begin
            psc_cnt <= tick ? '0 : psc_cnt + PSC_ONE;
        end
    end

    // Set has priority over the W1C clear.
    always_ff @(posedge H_CLK) begin
        if (H_RESET)                      expired <= 1'b0;
        else if (expire)                  expired <= 1'b1;
        else if (wr_status && P_WDATA[0]) expired <= 1'b0;
    end

    assign TIMER_IRQ = expired & irq_en;

    logic [DATA_WIDTH-1:0] rd_ctrl;
    logic [DATA_WIDTH-1:0] rd_status;

    always_comb begin
        rd_ctrl                         = '0;
        rd_ctrl[0]                      = en;
        rd_ctrl[1]                      = auto_reload;
        rd_ctrl[2]                      = irq_en;
        rd_ctrl[8 +: PRESCALE_WIDTH]    = prescale;
        rd_status                       = '0;
        rd_status[0]                    = expired;
    end

    always_comb begin
        P_RDATA = '0;
        if (P_SELx && !P_WRITE) begin
            unique case (reg_sel)
                OFF_CTRL:   P_RDATA = rd_ctrl;
                OFF_LOAD:   P_RDATA = load;
                OFF_VALUE:  P_RDATA = value;
                OFF_STATUS: P_RDATA = rd_status;
                default:    P_RDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: register table plus
// hand-written timing sequences, checked through a small scoreboard queue.
module tb_apb_timer_slave;

    logic        H_CLK = 1'b0;
    logic        H_RESET;
    logic        P_SELx;
    logic        P_ENABLE;
    logic        P_WRITE;
    logic [31:0] P_ADDR;
    logic [31:0] P_WDATA;
    logic [31:0] P_RDATA;
    logic        TIMER_IRQ;

    apb_timer_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .PRESCALE_WIDTH(8)
    ) dut (
        .H_CLK(H_CLK),
        .H_RESET(H_RESET),
        .P_SELx(P_SELx),
        .P_ENABLE(P_ENABLE),
        .P_WRITE(P_WRITE),
        .P_ADDR(P_ADDR),
        .P_WDATA(P_WDATA),
        .P_RDATA(P_RDATA),
        .TIMER_IRQ(TIMER_IRQ)
    );

    always #5 H_CLK = ~H_CLK;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_LOAD   = 32'h4;
    localparam logic [31:0] A_VALUE  = 32'h8;
    localparam logic [31:0] A_STATUS = 32'hC;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge H_CLK);
    endtask

    // Drive a read setup phase and compare the combinational read data.
    task automatic peek(input logic [31:0] addr, input logic [31:0] exp,
                        input string name);
        sb_t e;
        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        P_ADDR   = addr;
        sb_q.push_back('{name, exp});
        #1;
        e = sb_q.pop_front();
        chk(e.name, P_RDATA, e.exp);
    endtask

    task automatic irq_chk(input logic exp, input string name);
        sb_t e;
        sb_q.push_back('{name, {31'b0, exp}});
        #1;
        e = sb_q.pop_front();
        chk(e.name, {31'b0, TIMER_IRQ}, e.exp);
    endtask

    // Bridge-style write: setup, access, then idle; returns after commit edge.
    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b1;
        P_ADDR   = addr;
        P_WDATA  = data;
        cycle();
        P_ENABLE = 1'b1;
        cycle();
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
    endtask

    initial begin
        sb_t e;
        vt[0]  = '{1'b0, A_CTRL,   32'h0,         32'h0};
        vt[1]  = '{1'b0, A_LOAD,   32'h0,         32'h0};
        vt[2]  = '{1'b0, A_VALUE,  32'h0,         32'h0};
        vt[3]  = '{1'b0, A_STATUS, 32'h0,         32'h0};
        vt[4]  = '{1'b1, A_LOAD,   32'h0000_1234, 32'h0};
        vt[5]  = '{1'b0, A_LOAD,   32'h0,         32'h0000_1234};
        vt[6]  = '{1'b0, A_VALUE,  32'h0,         32'h0000_1234};
        vt[7]  = '{1'b1, A_CTRL,   32'hFFFF_FFFE, 32'h0};
        vt[8]  = '{1'b0, A_CTRL,   32'h0,         32'h0000_FF06};
        vt[9]  = '{1'b1, A_VALUE,  32'h0000_FFFF, 32'h0};
        vt[10] = '{1'b0, A_VALUE,  32'h0,         32'h0000_1234};
        vt[11] = '{1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0};
        vt[12] = '{1'b0, A_STATUS, 32'h0,         32'h0};
        vt[13] = '{1'b0, 32'h104,  32'h0,         32'h0000_1234};
        vt[14] = '{1'b1, A_CTRL,   32'h0,         32'h0};
        vt[15] = '{1'b0, A_CTRL,   32'h0,         32'h0};

        H_RESET  = 1'b1;
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        P_ADDR   = '0;
        P_WDATA  = '0;
        repeat (3) cycle();
        H_RESET = 1'b0;
        cycle();
        irq_chk(1'b0, "rst_irq");
        cycle();

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) begin
                apb_wr(vt[i].addr, vt[i].data);
            end else begin
                peek(vt[i].addr, vt[i].exp, $sformatf("tbl%0d", i));
                cycle();
            end
        end

        // One-shot, prescale 0, IRQ enabled
        apb_wr(A_LOAD, 32'h5);
        apb_wr(A_CTRL, 32'h5);
        for (int k = 5; k >= 0; k--) begin
            peek(A_VALUE, k, $sformatf("os_val%0d", k));
            if (k == 0) peek(A_STATUS, 32'h0, "os_st_early");
            cycle();
        end
        peek(A_STATUS, 32'h1, "os_expired");
        irq_chk(1'b1, "os_irq");
        peek(A_CTRL, 32'h4, "os_en_clr");
        peek(A_VALUE, 32'h0, "os_hold0");
        repeat (3) cycle();
        peek(A_VALUE, 32'h0, "os_hold0_late");
        cycle();
        apb_wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h0, "os_w1c");
        irq_chk(1'b0, "os_irq_drop");
        cycle();

        // Auto-reload, prescale 2, IRQ disabled
        apb_wr(A_LOAD, 32'h3);
        apb_wr(A_CTRL, 32'h0000_0203);
        for (int k = 0; k < 15; k++) begin
            peek(A_VALUE, 32'(3 - ((k / 3) % 4)), $sformatf("ar_val%0d", k));
            peek(A_STATUS, (k >= 12) ? 32'h1 : 32'h0, $sformatf("ar_st%0d", k));
            irq_chk(1'b0, $sformatf("ar_irq%0d", k));
            cycle();
        end
        apb_wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h0, "ar_w1c");
        peek(A_VALUE, 32'h2, "ar_val17");
        repeat (5) cycle();
        apb_wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h1, "ar_w1c_vs_set");
        peek(A_VALUE, 32'h3, "ar_reload");
        cycle();
        apb_wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h0, "ar_w1c2");
        cycle();
        apb_wr(A_CTRL, 32'h0);

        // Back-to-back CTRL then LOAD without returning to idle
        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b1;
        P_ADDR   = A_CTRL;
        P_WDATA  = 32'h0000_FF00;
        cycle();
        P_ENABLE = 1'b1;
        cycle();
        P_ENABLE = 1'b0;
        P_ADDR   = A_LOAD;
        P_WDATA  = 32'h7;
        cycle();
        P_ENABLE = 1'b1;
        cycle();
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        peek(A_CTRL, 32'h0000_FF00, "b2b_ctrl");
        peek(A_LOAD, 32'h7, "b2b_load");
        peek(A_VALUE, 32'h7, "b2b_value");
        cycle();

        // Access phase held for three cycles; data changes after the first
        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b1;
        P_ADDR   = A_LOAD;
        P_WDATA  = 32'hA;
        cycle();
        P_ENABLE = 1'b1;
        cycle();
        P_WDATA  = 32'hB;
        repeat (2) cycle();
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        peek(A_LOAD, 32'hA, "hold_load");
        peek(A_VALUE, 32'hA, "hold_value");
        cycle();
        apb_wr(A_VALUE, 32'h0000_FFFF);
        peek(A_VALUE, 32'hA, "ro_value");
        peek(A_LOAD, 32'hA, "ro_load");
        cycle();

        // LOAD write landing on a tick wins over the decrement
        apb_wr(A_CTRL, 32'h1);
        apb_wr(A_LOAD, 32'h20);
        peek(A_VALUE, 32'h20, "ld_vs_tick");
        cycle();
        peek(A_VALUE, 32'h1F, "ld_then_dec");
        cycle();

        // Reset during the access phase of a LOAD write while counting
        P_SELx   = 1'b1;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b1;
        P_ADDR   = A_LOAD;
        P_WDATA  = 32'h55;
        cycle();
        P_ENABLE = 1'b1;
        H_RESET  = 1'b1;
        cycle();
        H_RESET  = 1'b0;
        P_SELx   = 1'b0;
        P_ENABLE = 1'b0;
        P_WRITE  = 1'b0;
        sb_q.push_back('{"rd_desel", 32'h0});
        #1;
        e = sb_q.pop_front();
        chk(e.name, P_RDATA, e.exp);
        peek(A_LOAD, 32'h0, "rst_load");
        peek(A_VALUE, 32'h0, "rst_value");
        cycle();
        peek(A_CTRL, 32'h0, "rst_ctrl");
        peek(A_STATUS, 32'h0, "rst_status");
        irq_chk(1'b0, "rst_irq2");
        cycle();
        apb_wr(A_LOAD, 32'h66);
        peek(A_LOAD, 32'h66, "post_rst_load");
        peek(A_VALUE, 32'h66, "post_rst_value");
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
